rocket_launch_manager: RTL and testbench



---
 rtl/rocket_pkg.sv | 26 ++
 rtl/rocket_slot_allocator.sv | 29 ++
 rtl/rocket_launch_manager.sv | 201 ++++++++++++++++++++
 tb/tb_rocket_launch_manager.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocket_pkg.sv
// ---------------------------------------------------------------------------
// rocket_pkg
// Shared types and constants for the player rocket launch path.
//   coord_t        : 11-bit signed screen coordinate
//   speed_t        : 9-bit signed speed in (pixels/64) per frame
//   launch_state_t : launch manager FSM states
// ---------------------------------------------------------------------------
package rocket_pkg;

  typedef logic signed [10:0] coord_t;
  typedef logic signed [8:0]  speed_t;

  typedef enum logic [1:0] {
    S_READY,
    S_PENDING,
    S_COOLDOWN
  } launch_state_t;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int SCREEN_MAX_X           = 639;
  localparam int SCREEN_MAX_Y           = 479;

  // Width of the frame cooldown counter; COOLDOWN_FRAMES must fit in it.
  localparam int COOLDOWN_W = 8;

endpackage

// File: rtl/rocket_slot_allocator.sv
// ---------------------------------------------------------------------------
// rocket_slot_allocator
// Combinational picker for the next free rocket slot (lowest index wins).
// Ports:
//   isActive_i   : per-slot registered active flags
//   anyFree_o    : at least one slot is inactive
//   freeSelect_o : one-hot select of the lowest inactive slot (0 if none)
// ---------------------------------------------------------------------------
module rocket_slot_allocator #(
  parameter int NUM_SLOTS = 4
) (
  input  logic [NUM_SLOTS-1:0] isActive_i,
  output logic                 anyFree_o,
  output logic [NUM_SLOTS-1:0] freeSelect_o
);

  // Scan from the top down so the lowest free index is the last one written.
  always_comb begin
    anyFree_o    = ~(&isActive_i);
    freeSelect_o = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!isActive_i[i]) begin
        freeSelect_o    = '0;
        freeSelect_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rocket_launch_manager.sv
// ---------------------------------------------------------------------------
// rocket_launch_manager
// Owns the pool of player rocket slots: turns fire requests into single-slot
// launches, drives the shared launch bus, retires slots on border/hit and
// enforces a frame-based cooldown between launches.
// Optional feature macro: ROCKET_AUTOFIRE_EN (holding fire in S_READY counts
// as a request, giving repeated launches every COOLDOWN_FRAMES).
// Ports:
//   clk, resetN       : clock, asynchronous active-low reset
//   startOfFrame      : one-clock pulse per frame
//   gameEnable        : low flushes all rockets and returns to S_READY
//   fireKey           : fire button level (synchronous)
//   playerTopLeftX/Y  : player sprite position
//   reachedBorder     : per-slot border flag from the controllers
//   rocketHit         : per-slot collision pulse
//   isActive          : per-slot registered active flag
//   initialSpeed/X/Y  : shared launch bus, valid from the first active cycle
//   launchPulse       : one-clock pulse aligned with the new active bit
//   rocketsInFlight   : popcount of isActive
// ---------------------------------------------------------------------------
module rocket_launch_manager
  import rocket_pkg::*;
#(
  parameter int NUM_ROCKETS     = 4,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int ROCKET_SPEED    = -192,
  parameter int X_OFFSET        = 14,
  parameter int Y_OFFSET        = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   gameEnable,
  input  logic                   fireKey,
  input  logic signed [10:0]     playerTopLeftX,
  input  logic signed [10:0]     playerTopLeftY,
  input  logic [NUM_ROCKETS-1:0] reachedBorder,
  input  logic [NUM_ROCKETS-1:0] rocketHit,
  output logic [NUM_ROCKETS-1:0] isActive,
  output logic signed [8:0]      initialSpeed,
  output logic signed [10:0]     initialX,
  output logic signed [10:0]     initialY,
  output logic                   launchPulse,
  output logic [3:0]             rocketsInFlight
);

  launch_state_t           state_q, state_d;
  logic [COOLDOWN_W-1:0]   cooldown_q, cooldown_d;
  logic                    fireKey_q;
  logic [NUM_ROCKETS-1:0]  isActive_q, isActive_d;
  logic [1:0]              guard_q [NUM_ROCKETS];
  logic [1:0]              guard_d [NUM_ROCKETS];
  coord_t                  initialX_q, initialY_q;
  speed_t                  initialSpeed_q;
  logic                    launchPulse_q;

  logic                    fireEdge;
  logic                    fireReq;
  logic                    anyFree;
  logic [NUM_ROCKETS-1:0]  freeSelect;
  logic                    launch;
  logic [NUM_ROCKETS-1:0]  launchSelect;
  logic [NUM_ROCKETS-1:0]  retire;
  logic [3:0]              inFlight;

  assign fireEdge = fireKey & ~fireKey_q;

`ifdef ROCKET_AUTOFIRE_EN
  assign fireReq = fireKey | fireEdge;
`else
  assign fireReq = fireEdge;
`endif

  // Free slots come from the registered flags only, so a slot retired on
  // one edge cannot be relaunched before the following edge.
  rocket_slot_allocator #(
    .NUM_SLOTS(NUM_ROCKETS)
  ) uAllocator (
    .isActive_i  (isActive_q),
    .anyFree_o   (anyFree),
    .freeSelect_o(freeSelect)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_READY;
      cooldown_q <= '0;
    end else begin
      state_q    <= state_d;
      cooldown_q <= cooldown_d;
    end
  end

  // Next-state logic. A launch enters cooldown only when one is configured.
  always_comb begin
    state_d    = state_q;
    cooldown_d = cooldown_q;
    if (!gameEnable) begin
      state_d    = S_READY;
      cooldown_d = '0;
    end else begin
      case (state_q)
        S_READY: begin
          if (fireReq && !anyFree) begin
            state_d = S_PENDING;
          end
        end
        S_PENDING: ;
        S_COOLDOWN: begin
          if (startOfFrame) begin
            if (cooldown_q <= COOLDOWN_W'(1)) begin
              state_d    = S_READY;
              cooldown_d = '0;
            end else begin
              cooldown_d = cooldown_q - 1'b1;
            end
          end
        end
        default: state_d = S_READY;
      endcase
      if (launch) begin
        if (COOLDOWN_FRAMES > 0) begin
          state_d    = S_COOLDOWN;
          cooldown_d = COOLDOWN_W'(COOLDOWN_FRAMES);
        end else begin
          state_d = S_READY;
        end
      end
    end
  end

  // Output logic: launch decision, retire vector and next slot state.
  // Guarded slots ignore border/hit because the controller position is
  // stale for two cycles after activation.
  always_comb begin
    launch = gameEnable && anyFree &&
             (((state_q == S_READY) && fireReq) || (state_q == S_PENDING));
    launchSelect = launch ? freeSelect : '0;
    retire       = '0;
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      retire[i] = isActive_q[i] && (guard_q[i] == 2'd0) &&
                  (reachedBorder[i] || rocketHit[i]);
    end
    isActive_d = gameEnable ? ((isActive_q & ~retire) | launchSelect) : '0;
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      guard_d[i] = guard_q[i];
      if (!gameEnable) begin
        guard_d[i] = 2'd0;
      end else if (launchSelect[i]) begin
        guard_d[i] = 2'd2;
      end else if (guard_q[i] != 2'd0) begin
        guard_d[i] = guard_q[i] - 2'd1;
      end
    end
  end

  // Slot flags, guards, fire-key history and the launch bus. The bus is
  // loaded on the launch edge so it is valid with the new active bit and
  // holds otherwise, including across a gameEnable flush.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      fireKey_q      <= 1'b0;
      isActive_q     <= '0;
      launchPulse_q  <= 1'b0;
      initialX_q     <= '0;
      initialY_q     <= '0;
      initialSpeed_q <= '0;
      for (int i = 0; i < NUM_ROCKETS; i++) begin
        guard_q[i] <= 2'd0;
      end
    end else begin
      fireKey_q     <= fireKey;
      isActive_q    <= isActive_d;
      launchPulse_q <= launch;
      for (int i = 0; i < NUM_ROCKETS; i++) begin
        guard_q[i] <= guard_d[i];
      end
      if (launch) begin
        initialX_q     <= playerTopLeftX + coord_t'(X_OFFSET);
        initialY_q     <= playerTopLeftY - coord_t'(Y_OFFSET);
        initialSpeed_q <= speed_t'(ROCKET_SPEED);
      end
    end
  end

  always_comb begin
    inFlight = '0;
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      inFlight = inFlight + 4'(isActive_q[i]);
    end
  end

  assign isActive        = isActive_q;
  assign initialX        = initialX_q;
  assign initialY        = initialY_q;
  assign initialSpeed    = initialSpeed_q;
  assign launchPulse     = launchPulse_q;
  assign rocketsInFlight = inFlight;

endmodule

// File: tb/tb_rocket_launch_manager.sv
// ---------------------------------------------------------------------------
// tb_rocket_launch_manager
// Directed bench for rocket_launch_manager with default parameters
// (4 slots, 8-frame cooldown, speed -192, offsets +14/-16).
// ---------------------------------------------------------------------------
module tb_rocket_launch_manager;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               gameEnable;
  logic               fireKey;
  logic signed [10:0] playerTopLeftX;
  logic signed [10:0] playerTopLeftY;
  logic [3:0]         reachedBorder;
  logic [3:0]         rocketHit;
  logic [3:0]         isActive;
  logic signed [8:0]  initialSpeed;
  logic signed [10:0] initialX;
  logic signed [10:0] initialY;
  logic               launchPulse;
  logic [3:0]         rocketsInFlight;

  int checks = 0;
  int errors = 0;

  rocket_launch_manager dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .gameEnable     (gameEnable),
    .fireKey        (fireKey),
    .playerTopLeftX (playerTopLeftX),
    .playerTopLeftY (playerTopLeftY),
    .reachedBorder  (reachedBorder),
    .rocketHit      (rocketHit),
    .isActive       (isActive),
    .initialSpeed   (initialSpeed),
    .initialX       (initialX),
    .initialY       (initialY),
    .launchPulse    (launchPulse),
    .rocketsInFlight(rocketsInFlight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fire, input logic [3:0] hit,
                               input logic [3:0] border, input logic enable);
    fireKey       = fire;
    rocketHit     = hit;
    reachedBorder = border;
    gameEnable    = enable;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic setPlayer(input int x, input int y);
    playerTopLeftX = 11'(x);
    playerTopLeftY = 11'(y);
  endtask

  initial begin
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
    setPlayer(300, 400);
    tick(2);
    checkOutput("rst_isActive", isActive, 0);
    checkOutput("rst_initX", initialX, 0);
    checkOutput("rst_initY", initialY, 0);
    checkOutput("rst_speed", initialSpeed, 0);
    checkOutput("rst_pulse", launchPulse, 0);
    checkOutput("rst_inFlight", rocketsInFlight, 0);
    resetN = 1'b1;
    tick(2);

    // First launch from reset
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
    tick(1);
    checkOutput("l1_isActive", isActive, 4'b0001);
    checkOutput("l1_initX", initialX, 314);
    checkOutput("l1_initY", initialY, 384);
    checkOutput("l1_speed", initialSpeed, -192);
    checkOutput("l1_pulse", launchPulse, 1);
    tick(1);
    checkOutput("l1_pulseEnd", launchPulse, 0);
    fireKey = 1'b0;

    // Fill slots 1..3, spaced 9 frames
    frames(9);
    fireKey = 1'b1; tick(1);
    checkOutput("fill1", isActive, 4'b0011);
    fireKey = 1'b0;
    frames(9);
    fireKey = 1'b1; tick(1);
    checkOutput("fill2", isActive, 4'b0111);
    fireKey = 1'b0;
    frames(9);
    setPlayer(1020, -1020);
    fireKey = 1'b1; tick(1);
    checkOutput("fill3", isActive, 4'b1111);
    checkOutput("fill3_inFlight", rocketsInFlight, 4);
    checkOutput("wrapX", initialX, -1014);
    checkOutput("wrapY", initialY, 1012);
    fireKey = 1'b0;

    // Fifth edge with no free slot queues a request
    frames(9);
    setPlayer(100, 200);
    fireKey = 1'b1; tick(1);
    checkOutput("pend_isActive", isActive, 4'b1111);
    checkOutput("pend_pulse", launchPulse, 0);
    fireKey = 1'b0; tick(1);
    rocketHit = 4'b0100; tick(1);
    checkOutput("hit2_isActive", isActive, 4'b1011);
    checkOutput("hit2_inFlight", rocketsInFlight, 3);
    checkOutput("hit2_pulse", launchPulse, 0);
    rocketHit = 4'b0000; tick(1);
    checkOutput("relaunch_isActive", isActive, 4'b1111);
    checkOutput("relaunch_pulse", launchPulse, 1);
    checkOutput("relaunch_X", initialX, 114);
    checkOutput("relaunch_Y", initialY, 184);

    // Clear everything once guards have expired
    tick(3);
    rocketHit = 4'b1111; tick(1);
    checkOutput("clearAll", isActive, 4'b0000);
    rocketHit = 4'b0000;
    frames(9);

    // Cooldown: edges before the 8th frame are ignored
    setPlayer(300, 400);
    fireKey = 1'b1; tick(1);
    checkOutput("cd_first", isActive, 4'b0001);
    fireKey = 1'b0;
    frames(3);
    fireKey = 1'b1; tick(1);
    checkOutput("cd_ignored3", isActive, 4'b0001);
    checkOutput("cd_ignored3_pulse", launchPulse, 0);
    fireKey = 1'b0;
    frames(4);
    fireKey = 1'b1; tick(1);
    checkOutput("cd_ignored7", isActive, 4'b0001);
    fireKey = 1'b0;
    frames(1);
    fireKey = 1'b1; tick(1);
    checkOutput("cd_accepted", isActive, 4'b0011);
    checkOutput("cd_accepted_pulse", launchPulse, 1);
    fireKey = 1'b0;

    // Guard: border held from launch is ignored for two cycles
    tick(3);
    rocketHit = 4'b0011; tick(1);
    checkOutput("clear01", isActive, 4'b0000);
    rocketHit = 4'b0000;
    frames(8);
    reachedBorder = 4'b0001;
    fireKey = 1'b1; tick(1);
    checkOutput("guard_launch", isActive, 4'b0001);
    fireKey = 1'b0; tick(1);
    checkOutput("guard_e1", isActive, 4'b0001);
    tick(1);
    checkOutput("guard_e2", isActive, 4'b0001);
    tick(1);
    checkOutput("guard_e3", isActive, 4'b0000);
    reachedBorder = 4'b0000;

    // Retire slot 1 and fire in the same cycle with slot 0 busy
    frames(8);
    fireKey = 1'b1; tick(1);
    checkOutput("rr_slot0", isActive, 4'b0001);
    fireKey = 1'b0;
    frames(8);
    fireKey = 1'b1; tick(1);
    checkOutput("rr_slot1", isActive, 4'b0011);
    fireKey = 1'b0;
    frames(8);
    applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1);
    tick(1);
    checkOutput("rr_same", isActive, 4'b0101);
    checkOutput("rr_same_pulse", launchPulse, 1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b1);
    tick(1);
    checkOutput("rr_noReuse", isActive, 4'b0101);
    frames(8);
    fireKey = 1'b1; tick(1);
    checkOutput("rr_nextReq", isActive, 4'b0111);
    fireKey = 1'b0;

    // gameEnable flush with a pending request
    frames(8);
    setPlayer(200, 300);
    fireKey = 1'b1; tick(1);
    checkOutput("ge_full", isActive, 4'b1111);
    checkOutput("ge_fullX", initialX, 214);
    fireKey = 1'b0;
    frames(8);
    fireKey = 1'b1; tick(1);
    checkOutput("ge_pending", isActive, 4'b1111);
    fireKey = 1'b0; tick(1);
    gameEnable = 1'b0; tick(1);
    checkOutput("ge_flush", isActive, 4'b0000);
    checkOutput("ge_flush_inFlight", rocketsInFlight, 0);
    checkOutput("ge_busHold", initialX, 214);
    tick(1);
    checkOutput("ge_stillEmpty", isActive, 4'b0000);
    gameEnable = 1'b1; tick(1);
    checkOutput("ge_pendingDropped", isActive, 4'b0000);
    checkOutput("ge_pendingDropped_pulse", launchPulse, 0);
    setPlayer(50, 60);
    fireKey = 1'b1; tick(1);
    checkOutput("ge_relaunch", isActive, 4'b0001);
    checkOutput("ge_relaunchX", initialX, 64);
    checkOutput("ge_relaunchY", initialY, 44);
    fireKey = 1'b0;

    // Asynchronous reset mid-flight
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("arst_isActive", isActive, 0);
    checkOutput("arst_initX", initialX, 0);
    checkOutput("arst_inFlight", rocketsInFlight, 0);
    tick(1);
    resetN = 1'b1;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
